// File: rtl/cla_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder.
package cla_pkg;

  // Default operand width and bits per lookahead group / pipeline stage.
  localparam int DEF_WIDTH = 16;
  localparam int DEF_GROUP = 4;

  // Number of pipeline stages (and cycles of latency) for a given width/group.
  function automatic int stages_f(input int width, input int group);
    return width / group;
  endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-lookahead block: generate/propagate terms,
// flattened lookahead carries, sum, group carry-out and the carry into the
// top bit of the group (needed for signed overflow on the last stage).
module cla_group
  import cla_pkg::*;
#(
  parameter int GROUP = DEF_GROUP
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [GROUP-1:0] gen_s;
  logic [GROUP-1:0] prop_s;
  logic [GROUP:0]   carry_s;
  logic             term_s;

  assign gen_s  = a & b;
  assign prop_s = a ^ b;

  // Lookahead carries: c[i] = OR_j (g[j] & p[j+1..i-1]) | (p[0..i-1] & cin),
  // expanded so no carry depends on a lower computed carry.
  always_comb begin
    carry_s    = '0;
    term_s     = 1'b0;
    carry_s[0] = cin;
    for (int i = 1; i <= GROUP; i++) begin
      term_s = cin;
      for (int j = 0; j < i; j++) begin
        term_s = term_s & prop_s[j];
      end
      carry_s[i] = term_s;
      for (int j = 0; j < i; j++) begin
        term_s = gen_s[j];
        for (int m = j + 1; m < i; m++) begin
          term_s = term_s & prop_s[m];
        end
        carry_s[i] = carry_s[i] | term_s;
      end
    end
  end

  assign sum   = prop_s ^ carry_s[GROUP-1:0];
  assign cout  = carry_s[GROUP];
  assign c_msb = carry_s[GROUP-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined adder/subtractor: one CLA group per stage, carry registered
// between stages, upper operand slices skewed in and finished lower sum
// slices deskewed out so Q, ovf and out_valid leave together, registered.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GROUP = DEF_GROUP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  output logic [WIDTH:0]   Q,
  output logic             ovf
);

  localparam int STAGES = stages_f(WIDTH, GROUP);

  // Operand conditioning: subtraction is A + ~B + 1, cin ignored.
  logic [WIDTH-1:0] b_eff_s;
  logic             c0_s;

  // Per-stage operands, carry-in and CLA results.
  logic [GROUP-1:0] a_stage_s   [STAGES];
  logic [GROUP-1:0] b_stage_s   [STAGES];
  logic [GROUP-1:0] sum_stage_s [STAGES];
  logic             carry_in_s  [STAGES];
  logic             cout_s      [STAGES];
  logic             c_msb_s     [STAGES];
  logic [GROUP-1:0] q_slice_s   [STAGES];

  // Output side.
  logic [STAGES-1:0] valid_r;
  logic [WIDTH:0]    q_r;
  logic              ovf_r;
  logic [WIDTH-1:0]  q_next_s;
  logic              ovf_next_s;

  // Select B polarity and stage-0 carry from the operation type.
  always_comb begin
    b_eff_s = B;
    c0_s    = cin;
    if (sub) begin
      b_eff_s = ~B;
      c0_s    = 1'b1;
    end else begin
      b_eff_s = B;
      c0_s    = cin;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage

    cla_group #(
      .GROUP (GROUP)
    ) u_cla (
      .a     (a_stage_s[k]),
      .b     (b_stage_s[k]),
      .cin   (carry_in_s[k]),
      .sum   (sum_stage_s[k]),
      .cout  (cout_s[k]),
      .c_msb (c_msb_s[k])
    );

    if (k == 0) begin : g_head
      // Stage 0 works straight off the inputs; its result is registered below.
      assign a_stage_s[k]  = A[GROUP-1:0];
      assign b_stage_s[k]  = b_eff_s[GROUP-1:0];
      assign carry_in_s[k] = c0_s;
    end else begin : g_skew
      logic [GROUP-1:0] a_skew_r [k];
      logic [GROUP-1:0] b_skew_r [k];
      logic             carry_r;

      // Delay this slice k cycles so it meets the carry rippling up the pipe.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          carry_r <= 1'b0;
          for (int i = 0; i < k; i++) begin
            a_skew_r[i] <= '0;
            b_skew_r[i] <= '0;
          end
        end else if (enable) begin
          carry_r     <= cout_s[k-1];
          a_skew_r[0] <= A[k*GROUP +: GROUP];
          b_skew_r[0] <= b_eff_s[k*GROUP +: GROUP];
          for (int i = 1; i < k; i++) begin
            a_skew_r[i] <= a_skew_r[i-1];
            b_skew_r[i] <= b_skew_r[i-1];
          end
        end
      end

      assign a_stage_s[k]  = a_skew_r[k-1];
      assign b_stage_s[k]  = b_skew_r[k-1];
      assign carry_in_s[k] = carry_r;
    end

    if (k < STAGES - 1) begin : g_deskew
      localparam int DEPTH = STAGES - 1 - k;
      logic [GROUP-1:0] sum_dly_r [DEPTH];

      // Hold the finished low slice until the top slice of the same operation is done.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            sum_dly_r[i] <= '0;
          end
        end else if (enable) begin
          sum_dly_r[0] <= sum_stage_s[k];
          for (int i = 1; i < DEPTH; i++) begin
            sum_dly_r[i] <= sum_dly_r[i-1];
          end
        end
      end

      assign q_slice_s[k] = sum_dly_r[DEPTH-1];
    end else begin : g_tail
      // Top slice goes directly into the output register.
      assign q_slice_s[k] = sum_stage_s[k];
    end
  end

  // Assemble the whole result word and signed overflow from the top stage.
  always_comb begin
    q_next_s = '0;
    for (int i = 0; i < STAGES; i++) begin
      q_next_s[i*GROUP +: GROUP] = q_slice_s[i];
    end
    ovf_next_s = c_msb_s[STAGES-1] ^ cout_s[STAGES-1];
  end

  // Valid chain and registered outputs, frozen while enable is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= '0;
      q_r     <= '0;
      ovf_r   <= 1'b0;
    end else if (enable) begin
      valid_r[0] <= in_valid;
      for (int i = 1; i < STAGES; i++) begin
        valid_r[i] <= valid_r[i-1];
      end
      q_r   <= {cout_s[STAGES-1], q_next_s};
      ovf_r <= ovf_next_s;
    end
  end

  assign out_valid = valid_r[STAGES-1];
  assign Q         = q_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed bench for cla_pipe_adder at WIDTH=16, GROUP=4 (latency 4).
module tb_cla_pipe_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        in_valid;
  logic [15:0] A;
  logic [15:0] B;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic [16:0] Q;
  logic        ovf;

  int errors = 0;
  int checks = 0;

  cla_pipe_adder #(
    .WIDTH (16),
    .GROUP (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .Q         (Q),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; in_valid = 1'b0;
    A = 16'h0000; B = 16'h0000; cin = 1'b0; sub = 1'b0;
    #12;
    checks++;
    if (out_valid !== 1'b0 || Q !== 17'h00000 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got v=%b Q=%h ovf=%b, want v=0 Q=00000 ovf=0", out_valid, Q, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [15:0] va [8];
    logic [15:0] vb [8];
    logic        vc [8];
    logic        vs [8];
    logic [16:0] eq [8];
    logic        eo [8];
    va[0]=16'h0000; vb[0]=16'h0005; vc[0]=1'b0; vs[0]=1'b0; eq[0]=17'h00005; eo[0]=1'b0;
    va[1]=16'hFFFF; vb[1]=16'h0001; vc[1]=1'b0; vs[1]=1'b0; eq[1]=17'h10000; eo[1]=1'b0;
    va[2]=16'h7FFF; vb[2]=16'h0001; vc[2]=1'b0; vs[2]=1'b0; eq[2]=17'h08000; eo[2]=1'b1;
    va[3]=16'h0005; vb[3]=16'h0007; vc[3]=1'b0; vs[3]=1'b1; eq[3]=17'h0FFFE; eo[3]=1'b0;
    va[4]=16'h8000; vb[4]=16'h0001; vc[4]=1'b0; vs[4]=1'b1; eq[4]=17'h17FFF; eo[4]=1'b1;
    va[5]=16'h1234; vb[5]=16'h1111; vc[5]=1'b1; vs[5]=1'b0; eq[5]=17'h02346; eo[5]=1'b0;
    va[6]=16'h0010; vb[6]=16'h0010; vc[6]=1'b1; vs[6]=1'b1; eq[6]=17'h10000; eo[6]=1'b0;
    va[7]=16'h8000; vb[7]=16'h8000; vc[7]=1'b0; vs[7]=1'b0; eq[7]=17'h10000; eo[7]=1'b1;
    for (int n = 0; n < 8; n++) begin
      enable = 1'b1;
      A = va[n]; B = vb[n]; cin = vc[n]; sub = vs[n]; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL basic_early_%0d: out_valid=%b after 3 edges, want 0", n, out_valid);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || Q !== eq[n] || ovf !== eo[n]) begin
        errors++;
        $display("FAIL basic_%0d: got v=%b Q=%h ovf=%b, want v=1 Q=%h ovf=%b",
                 n, out_valid, Q, ovf, eq[n], eo[n]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [6];
    logic [15:0] vb [6];
    logic        vc [6];
    logic        vs [6];
    logic [16:0] eq [6];
    logic        eo [6];
    logic [16:0] hold_q;
    logic        hold_v;
    logic        hold_o;
    int          got;
    va[0]=16'h0001; vb[0]=16'h0002; vc[0]=1'b0; vs[0]=1'b0; eq[0]=17'h00003; eo[0]=1'b0;
    va[1]=16'h00FF; vb[1]=16'h0001; vc[1]=1'b1; vs[1]=1'b0; eq[1]=17'h00101; eo[1]=1'b0;
    va[2]=16'h1000; vb[2]=16'h0001; vc[2]=1'b0; vs[2]=1'b1; eq[2]=17'h10FFF; eo[2]=1'b0;
    va[3]=16'h4000; vb[3]=16'h4000; vc[3]=1'b0; vs[3]=1'b0; eq[3]=17'h08000; eo[3]=1'b1;
    va[4]=16'hAAAA; vb[4]=16'h5555; vc[4]=1'b1; vs[4]=1'b0; eq[4]=17'h10000; eo[4]=1'b0;
    va[5]=16'h0003; vb[5]=16'h0003; vc[5]=1'b0; vs[5]=1'b1; eq[5]=17'h10000; eo[5]=1'b0;
    got = 0;
    hold_q = '0; hold_v = 1'b0; hold_o = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cyc < 3) begin
        enable = 1'b1; in_valid = 1'b1;
        A = va[cyc]; B = vb[cyc]; cin = vc[cyc]; sub = vs[cyc];
      end else if (cyc < 6) begin
        enable = 1'b0; in_valid = 1'b1;
        A = 16'hDEAD; B = 16'hBEEF; cin = 1'b1; sub = 1'b0;
      end else if (cyc < 9) begin
        enable = 1'b1; in_valid = 1'b1;
        A = va[cyc-3]; B = vb[cyc-3]; cin = vc[cyc-3]; sub = vs[cyc-3];
      end else begin
        enable = 1'b1; in_valid = 1'b0;
      end
      step();
      if (cyc == 2) begin
        hold_q = Q; hold_v = out_valid; hold_o = ovf;
      end
      if (cyc >= 3 && cyc < 6) begin
        checks++;
        if (Q !== hold_q || out_valid !== hold_v || ovf !== hold_o) begin
          errors++;
          $display("FAIL stall_freeze_%0d: got v=%b Q=%h ovf=%b, want v=%b Q=%h ovf=%b",
                   cyc, out_valid, Q, ovf, hold_v, hold_q, hold_o);
        end
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (got >= 6) begin
          errors++;
          $display("FAIL b2b_extra: unexpected result Q=%h at edge %0d, want none", Q, cyc + 1);
        end else if (Q !== eq[got] || ovf !== eo[got] || (cyc + 1) !== (7 + got)) begin
          errors++;
          $display("FAIL b2b_%0d: got Q=%h ovf=%b at edge %0d, want Q=%h ovf=%b at edge %0d",
                   got, Q, ovf, cyc + 1, eq[got], eo[got], 7 + got);
        end
        got++;
      end
    end
    checks++;
    if (got !== 6) begin
      errors++;
      $display("FAIL b2b_count: got %0d results, want 6", got);
    end
  endtask

  task automatic test_reset_inflight();
    int stale;
    enable = 1'b1; cin = 1'b0; sub = 1'b0;
    for (int n = 0; n < 3; n++) begin
      in_valid = 1'b1; A = 16'h1111 * 16'(n + 1); B = 16'h2222;
      step();
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b1 || Q !== 17'h03333) begin
      errors++;
      $display("FAIL pre_reset: got v=%b Q=%h, want v=1 Q=03333", out_valid, Q);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || Q !== 17'h00000 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got v=%b Q=%h ovf=%b, want v=0 Q=00000 ovf=0", out_valid, Q, ovf);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int n = 0; n < 8; n++) begin
      step();
      if (out_valid !== 1'b0) stale++;
    end
    checks++;
    if (stale !== 0) begin
      errors++;
      $display("FAIL stale_after_reset: saw %0d valid cycles, want 0", stale);
    end
    A = 16'h0005; B = 16'h0003; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_early: out_valid=%b after 3 edges, want 0", out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || Q !== 17'h00008 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_op: got v=%b Q=%h ovf=%b, want v=1 Q=00008 ovf=0", out_valid, Q, ovf);
    end
  endtask

  task automatic test_random_bubbles();
    logic        hist [80];
    logic [16:0] eq_q [$];
    logic        eo_q [$];
    logic [15:0] bp;
    logic [16:0] s17;
    logic [16:0] wq;
    logic        wo;
    enable = 1'b1;
    for (int t = 0; t < 64; t++) begin
      in_valid = (t < 60) ? ($urandom_range(0, 3) != 0) : 1'b0;
      A   = 16'($urandom);
      B   = 16'($urandom);
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      hist[t] = in_valid;
      if (in_valid) begin
        bp  = sub ? ~B : B;
        s17 = 17'(A) + 17'(bp) + 17'(sub ? 1'b1 : cin);
        eq_q.push_back(s17);
        eo_q.push_back((A[15] == bp[15]) && (s17[15] != A[15]));
      end
      step();
      if (t >= 3) begin
        checks++;
        if (out_valid !== hist[t-3]) begin
          errors++;
          $display("FAIL rand_valid_%0d: out_valid=%b, want %b", t, out_valid, hist[t-3]);
        end
        if (out_valid === 1'b1 && eq_q.size() > 0) begin
          wq = eq_q.pop_front();
          wo = eo_q.pop_front();
          checks++;
          if (Q !== wq || ovf !== wo) begin
            errors++;
            $display("FAIL rand_data_%0d: got Q=%h ovf=%b, want Q=%h ovf=%b", t, Q, ovf, wq, wo);
          end
        end
      end
    end
    checks++;
    if (eq_q.size() !== 0) begin
      errors++;
      $display("FAIL rand_drain: %0d results missing, want 0", eq_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_reset_inflight();
    test_random_bubbles();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
